// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC vectoring engine.
// The COMP state exists only when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

  localparam int unsigned ANGLE_W  = 18;
  localparam int unsigned ZW       = 19;
  localparam int unsigned ITER_MAX = 18;

  localparam logic signed [ZW-1:0] PI_HALF = 19'sh19220;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
`ifdef CORDIC_GAIN_COMP_EN
    S_COMP = 2'd2,
`endif
    S_OUT  = 2'd3
  } state_t;

  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 (0.607300)
  function automatic logic signed [31:0] inv_gain(input logic signed [31:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
  endfunction

endpackage

// File: rtl/cordic_vec_prerot.sv
// Quadrant pre-rotation: folds (x, y) into the right half-plane so the
// micro-rotations only have to cover +-pi/2.
module cordic_vec_prerot
  import cordic_pkg::*;
#(
  parameter int unsigned W = 20
) (
  input  logic [ANGLE_W-1:0]   i_x,
  input  logic [ANGLE_W-1:0]   i_y,
  output logic signed [W-1:0]  o_x,
  output logic signed [W-1:0]  o_y,
  output logic signed [ZW-1:0] o_z,
  output logic                 o_zero
);

  logic signed [W-1:0] w_x;
  logic signed [W-1:0] w_y;

  assign w_x    = {{(W-ANGLE_W){i_x[ANGLE_W-1]}}, i_x};
  assign w_y    = {{(W-ANGLE_W){i_y[ANGLE_W-1]}}, i_y};
  assign o_zero = (i_x == '0) && (i_y == '0);

  always_comb begin
    o_x = w_x;
    o_y = w_y;
    o_z = '0;
    if (w_x[W-1]) begin
      if (!w_y[W-1]) begin
        o_x = w_y;
        o_y = -w_x;
        o_z = PI_HALF;
      end else begin
        o_x = -w_y;
        o_y = w_x;
        o_z = -PI_HALF;
      end
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2 angle and magnitude.
// Define CORDIC_GAIN_COMP_EN to add a 1/K gain-compensation cycle.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = 16,
  parameter int unsigned W    = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ANGLE_W-1:0] x_in,
  input  logic [ANGLE_W-1:0] y_in,
  output logic               ready,
  output logic               valid,
  output logic [ZW-1:0]      angle_out,
  output logic [19:0]        mag_out,
  output logic [4:0]         lut_index,
  input  logic [ANGLE_W-1:0] lut_angle
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic signed [W-1:0]  r_x;
  logic signed [W-1:0]  r_y;
  logic signed [ZW-1:0] r_z;
  logic [4:0]           r_i;
  logic                 r_zero;
  logic                 r_valid;
  logic [ZW-1:0]        r_angle;
  logic [19:0]          r_mag;

  logic signed [W-1:0]  w_x_pre;
  logic signed [W-1:0]  w_y_pre;
  logic signed [ZW-1:0] w_z_pre;
  logic                 w_zero;
  logic signed [ZW-1:0] w_a;
  logic                 w_last;

  cordic_vec_prerot #(.W(W)) u_prerot (
    .i_x    (x_in),
    .i_y    (y_in),
    .o_x    (w_x_pre),
    .o_y    (w_y_pre),
    .o_z    (w_z_pre),
    .o_zero (w_zero)
  );

  assign w_a    = {{(ZW-ANGLE_W){lut_angle[ANGLE_W-1]}}, lut_angle};
  assign w_last = (r_i == 5'(ITER - 1));

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [W-1:0] w_x_comp;
  assign w_x_comp = W'(inv_gain(32'(r_x)));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = (r_state == S_IDLE);
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_ITER;
`ifdef CORDIC_GAIN_COMP_EN
      S_ITER: if (w_last) w_state_nxt = S_COMP;
      S_COMP: w_state_nxt = S_OUT;
`else
      S_ITER: if (w_last) w_state_nxt = S_OUT;
`endif
      S_OUT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
      r_angle <= '0;
      r_mag   <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x    <= w_x_pre;
            r_y    <= w_y_pre;
            r_z    <= w_z_pre;
            r_i    <= '0;
            r_zero <= w_zero;
          end
        end
        S_ITER: begin
          // Drive y toward zero; z accumulates the rotation actually applied.
          if (!r_y[W-1]) begin
            r_x <= r_x + (r_y >>> r_i);
            r_y <= r_y - (r_x >>> r_i);
            r_z <= r_z + w_a;
          end else begin
            r_x <= r_x - (r_y >>> r_i);
            r_y <= r_y + (r_x >>> r_i);
            r_z <= r_z - w_a;
          end
          if (!w_last) r_i <= r_i + 5'd1;
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_COMP: r_x <= w_x_comp;
`endif
        S_OUT: begin
          r_valid <= 1'b1;
          r_angle <= r_zero ? '0 : r_z;
          r_mag   <= r_zero ? '0 : 20'(r_x);
        end
        default: ;
      endcase
    end
  end

  assign valid     = r_valid;
  assign angle_out = r_angle;
  assign mag_out   = r_mag;
  assign lut_index = r_i;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring; follows CORDIC_GAIN_COMP_EN for
// expected latency and gain.
module tb_cordic_vectoring;

  localparam int unsigned ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = ITER + 2;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = ITER + 1;
  localparam bit COMP = 1'b0;
`endif
  localparam int ANG_TOL = 8;
  localparam int MAG_TOL = 16;
  localparam int PI_LSB  = 205887;
  localparam int TWO_PI  = 411775;

  typedef struct {
    int ang;
    int mag;
    bit zero;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [17:0] x_in  = '0;
  logic [17:0] y_in  = '0;
  logic        ready;
  logic        valid;
  logic [18:0] angle_out;
  logic [19:0] mag_out;
  logic [4:0]  lut_index;
  logic [17:0] lut_angle;

  logic [17:0] atan_tbl [32];
  exp_t        sb [$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  assign lut_angle = atan_tbl[lut_index];

  cordic_vectoring #(.ITER(ITER), .W(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .ready     (ready),
    .valid     (valid),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .lut_index (lut_index),
    .lut_angle (lut_angle)
  );

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    real  rx = x;
    real  ry = y;
    real  k  = 1.0;
    for (int i = 0; i < int'(ITER); i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    e.zero = (x == 0) && (y == 0);
    if (e.zero) begin
      e.ang = 0;
      e.mag = 0;
    end else begin
      e.ang = rnd($atan2(ry, rx) * 65536.0);
      e.mag = rnd($sqrt(rx * rx + ry * ry) * (COMP ? 1.0 : k));
    end
    return e;
  endfunction

  function automatic int ang_err(input int got, input int want);
    int d = got - want;
    if (d > PI_LSB) d -= TWO_PI;
    else if (d < -PI_LSB) d += TWO_PI;
    return (d < 0) ? -d : d;
  endfunction

  // Called at a negedge with ready=1; returns at the negedge after the start edge.
  task automatic issue(input int x, input int y);
    sb.push_back(model(x, y));
    x_in  = 18'(x);
    y_in  = 18'(y);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_in  = 18'($urandom);
    y_in  = 18'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      lat++;
      if (valid) return;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: ready=%b valid=%b required ready=1 valid=0", ready, valid);
    end
    checks++;
    if (angle_out !== '0 || mag_out !== '0 || lut_index !== '0) begin
      failures++;
      $display("FAIL reset_out: angle=%0d mag=%0d idx=%0d required 0 0 0", angle_out, mag_out, lut_index);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    int   vx [8] = '{65536, 0, -65536, -65536, 65536, -40000, 12345, 0};
    int   vy [8] = '{0, 65536, 0, -1, 65536, 30000, -54321, -65536};
    int   lat;
    exp_t e;
    for (int t = 0; t < 8; t++) begin
      issue(vx[t], vy[t]);
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_fall[%0d]: got %b required 0", t, ready);
      end
      wait_valid(lat);
      e = sb.pop_front();
      checks++;
      if (lat != LAT) begin
        failures++;
        $display("FAIL latency[%0d]: got %0d required %0d", t, lat, LAT);
      end
      if (lat < 0) continue;
      checks++;
      if (ready !== 1'b1) begin
        failures++;
        $display("FAIL ready_rise[%0d]: got %b required 1", t, ready);
      end
      checks++;
      if (ang_err(int'($signed(angle_out)), e.ang) > ANG_TOL) begin
        failures++;
        $display("FAIL angle[%0d]: got %0d required %0d +-%0d", t, $signed(angle_out), e.ang, ANG_TOL);
      end
      checks++;
      if (ang_err(int'(mag_out), e.mag) > MAG_TOL) begin
        failures++;
        $display("FAIL mag[%0d]: got %0d required %0d +-%0d", t, mag_out, e.mag, MAG_TOL);
      end
      @(negedge clk);
      checks++;
      if (valid !== 1'b0) begin
        failures++;
        $display("FAIL valid_pulse[%0d]: got %b required 0", t, valid);
      end
    end
  endtask

  task automatic test_zero_ignore();
    int   lat = 0;
    int   early_ready = 0;
    int   extra = 0;
    exp_t e;
    issue(0, 0);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      lat++;
      if (valid) break;
      if (ready) early_ready++;
      if (lat == 5) begin
        x_in  = 18'(65536);
        y_in  = 18'(65536);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (lat != LAT || !valid) begin
      failures++;
      $display("FAIL zero_latency: got %0d valid=%b required %0d", lat, valid, LAT);
    end
    checks++;
    if (early_ready != 0) begin
      failures++;
      $display("FAIL zero_ready_low: got %0d early ready cycles required 0", early_ready);
    end
    checks++;
    if (int'($signed(angle_out)) != e.ang || int'(mag_out) != e.mag) begin
      failures++;
      $display("FAIL zero_result: got angle=%0d mag=%0d required %0d %0d", $signed(angle_out), mag_out, e.ang, e.mag);
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignored_start: got %0d extra valid pulses required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    issue(30000, 20000);
    wait_valid(lat);
    e = sb.pop_front();
    checks++;
    if (lat != LAT || ang_err(int'($signed(angle_out)), e.ang) > ANG_TOL) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d angle=%0d required %0d %0d", lat, $signed(angle_out), LAT, e.ang);
    end
    issue(-20000, -25000);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: ready=%b required 0", ready);
    end
    wait_valid(lat);
    e = sb.pop_front();
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL b2b_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (ang_err(int'($signed(angle_out)), e.ang) > ANG_TOL || ang_err(int'(mag_out), e.mag) > MAG_TOL) begin
      failures++;
      $display("FAIL b2b_second: got angle=%0d mag=%0d required %0d %0d", $signed(angle_out), mag_out, e.ang, e.mag);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int   lat;
    int   extra = 0;
    bit   found = 1'b0;
    exp_t e;
    issue(65536, 32768);
    for (int n = 0; n < 40; n++) begin
      if (lut_index == 5'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_iter7: got no index 7 required index 7 within 40 cycles");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (angle_out !== '0 || mag_out !== '0 || ready !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got angle=%0d mag=%0d ready=%b valid=%b required 0 0 1 0", angle_out, mag_out, ready, valid);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL reset_no_valid: got %0d valid pulses required 0", extra);
    end
    issue(-30000, 45000);
    wait_valid(lat);
    e = sb.pop_front();
    checks++;
    if (lat != LAT || ang_err(int'($signed(angle_out)), e.ang) > ANG_TOL || ang_err(int'(mag_out), e.mag) > MAG_TOL) begin
      failures++;
      $display("FAIL after_reset: lat=%0d angle=%0d mag=%0d required %0d %0d %0d", lat, $signed(angle_out), mag_out, LAT, e.ang, e.mag);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) atan_tbl[i] = 18'(rnd($atan(2.0 ** (-1.0 * i)) * 65536.0));
    test_reset();
    test_vectors();
    test_zero_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
